stopwatch_display: RTL and testbench

- Downstream consumer of the minute/second counter stage of the stopwatch.
- Takes the live 6-bit minutes/seconds values plus the adj/sel mode inputs.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display as MM.SS.
- Blinks the field being adjusted so the user can see which one the buttons affect.

---
 rtl/stopwatch_pkg.sv | 48 ++++
 rtl/stopwatch_display_seg7_decoder.sv | 27 ++
 rtl/stopwatch_display.sv | 103 ++++++++++
 tb/tb_stopwatch_display.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch display path.
package stopwatch_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIG_W      = 2;
  localparam int unsigned FIELD_W    = 6;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_FIELD  = 59;

  // Digit slots, rightmost first.
  typedef enum logic [DIG_W-1:0] {
    DIG_SEC_ONES = 2'd0,
    DIG_SEC_TENS = 2'd1,
    DIG_MIN_ONES = 2'd2,
    DIG_MIN_TENS = 2'd3
  } digit_e;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } phase_e;

  // Decoder input codes beyond the decimal digits.
  localparam logic [CODE_W-1:0] CODE_DASH  = 4'hA;
  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;

  // Active-low {g,f,e,d,c,b,a} patterns.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Tens or ones decimal digit of a 0..59 field value.
  function automatic logic [CODE_W-1:0] bcd_digit(input logic [FIELD_W-1:0] value,
                                                  input logic tens);
    return tens ? CODE_W'(value / 6'd10) : CODE_W'(value % 6'd10);
  endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decoder.sv
// Combinational digit code to active-low seven-segment pattern.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (code)
      4'd0:      seg_c = SEG_0;
      4'd1:      seg_c = SEG_1;
      4'd2:      seg_c = SEG_2;
      4'd3:      seg_c = SEG_3;
      4'd4:      seg_c = SEG_4;
      4'd5:      seg_c = SEG_5;
      4'd6:      seg_c = SEG_6;
      4'd7:      seg_c = SEG_7;
      4'd8:      seg_c = SEG_8;
      4'd9:      seg_c = SEG_9;
      CODE_DASH: seg_c = SEG_DASH;
      default:   seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed MM.SS seven-segment driver with blinking of the field under adjustment.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FIELD_W-1:0] minutes,
  input  logic [FIELD_W-1:0] seconds,
  input  logic               adj,
  input  logic               sel,
  output logic [3:0]         an,
  output logic [7:0]         seg
);

  localparam int unsigned REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FIELD_W-1:0] min_q, sec_q;
  logic               adj_q, sel_q;
  logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  digit_e             dig_q, dig_d;
  phase_e             phase_q, phase_d;

  logic [FIELD_W-1:0] field;
  logic [CODE_W-1:0]  code;
  logic [SEG_W-1:0]   dec_seg_c;
  logic               blank;
  logic [3:0]         an_d;
  logic [7:0]         seg_d;

  // State registers: input capture, scan/blink counters, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q       <= '0;
      sec_q       <= '0;
      adj_q       <= 1'b0;
      sel_q       <= 1'b0;
      ref_cnt_q   <= '0;
      blink_cnt_q <= '0;
      dig_q       <= DIG_SEC_ONES;
      phase_q     <= PH_VISIBLE;
      an          <= 4'b1111;
      seg         <= 8'hFF;
    end else begin
      min_q       <= minutes;
      sec_q       <= seconds;
      adj_q       <= adj;
      sel_q       <= sel;
      ref_cnt_q   <= ref_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      dig_q       <= dig_d;
      phase_q     <= phase_d;
      an          <= an_d;
      seg         <= seg_d;
    end
  end

  // Next-state: digit scan and blink phase.
  always_comb begin
    ref_cnt_d   = ref_cnt_q + REF_W'(1);
    dig_d       = dig_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      dig_d     = digit_e'(dig_q + 2'd1);
    end

    if (!adj_q) begin
      blink_cnt_d = '0;
      phase_d     = PH_VISIBLE;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  // Output mux: pick field/digit, dash out-of-range fields, blank the selected field when hidden.
  always_comb begin
    field = dig_q[1] ? min_q : sec_q;
    code  = bcd_digit(field, dig_q[0]);
    if (field > FIELD_W'(MAX_FIELD)) begin
      code = CODE_DASH;
    end
    // sel=1 targets seconds (dig_q[1]=0), sel=0 targets minutes.
    blank = adj_q && (phase_q == PH_HIDDEN) && (dig_q[1] != sel_q);
    an_d  = blank ? 4'b1111 : 4'(~(4'b0001 << dig_q));
    seg_d = {(blank || (dig_q != DIG_MIN_ONES)), dec_seg_c};
  end

  seg7_decoder u_dec (
    .code  (blank ? CODE_BLANK : code),
    .seg_c (dec_seg_c)
  );

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with a cycle-counting reference model.
module tb_stopwatch_display;

  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned BLINK_DIV   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] minutes = 6'd0;
  logic [5:0] seconds = 6'd0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stopwatch_display #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .minutes (minutes),
    .seconds (seconds),
    .adj     (adj),
    .sel     (sel),
    .an      (an),
    .seg     (seg)
  );

  logic [6:0] digit_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

  // Model state: edges since reset, consecutive adj-high edges, last-sampled inputs.
  int         m_edges = 0;
  int         m_adj_run = 0;
  logic [5:0] m_min = 6'd0;
  logic [5:0] m_sec = 6'd0;
  logic       m_adj = 1'b0;
  logic       m_sel = 1'b0;
  logic [3:0] exp_an = 4'hF;
  logic [7:0] exp_seg = 8'hFF;

  function automatic logic [11:0] model_out(input int edges, input int adj_run,
                                            input logic [5:0] mn, input logic [5:0] sc,
                                            input logic a, input logic s);
    int d;
    int v;
    logic hidden;
    logic [6:0] g;
    d = (edges / REFRESH_DIV) % 4;
    v = (d >= 2) ? int'(mn) : int'(sc);
    hidden = a && (((adj_run / BLINK_DIV) % 2) == 1) && ((d < 2) == s);
    if (hidden) return {4'hF, 8'hFF};
    if (v > 59) g = 7'b0111111;
    else        g = digit_tbl[(d % 2 == 1) ? v / 10 : v % 10];
    return {~(4'b0001 << d), ((d == 2) ? 1'b0 : 1'b1), g};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges   <= 0;
      m_adj_run <= 0;
      m_min     <= 6'd0;
      m_sec     <= 6'd0;
      m_adj     <= 1'b0;
      m_sel     <= 1'b0;
      exp_an    <= 4'hF;
      exp_seg   <= 8'hFF;
    end else begin
      {exp_an, exp_seg} <= model_out(m_edges, m_adj_run, m_min, m_sec, m_adj, m_sel);
      m_edges   <= m_edges + 1;
      m_adj_run <= m_adj ? m_adj_run + 1 : 0;
      m_min     <= minutes;
      m_sec     <= seconds;
      m_adj     <= adj;
      m_sel     <= sel;
    end
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: an/seg got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] a, input logic [7:0] s);
    check(name, {an, seg}, {a, s});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) check("model", {an, seg}, {exp_an, exp_seg});
  end

  initial begin
    minutes = 6'd12;
    seconds = 6'd34;
    step(1);
    chk_en = 1'b1;
    lit("reset_state", 4'hF, 8'hFF);
    step(1);
    rst_n = 1'b1;

    step(1); lit("first_an",   4'b1110, 8'hC0);
    step(1); lit("d0_four",    4'b1110, 8'h99);
    step(3); lit("d1_three",   4'b1101, 8'hB0);
    step(4); lit("d2_two_dp",  4'b1011, 8'h24);
    step(4); lit("d3_one",     4'b0111, 8'hF9);
    step(4); lit("wrap_d0",    4'b1110, 8'h99);

    minutes = 6'd59;
    seconds = 6'd59;
    step(16); lit("d0_nine",   4'b1110, 8'h90);
    seconds = 6'd0;
    step(1); lit("lat_old",    4'b1110, 8'h90);
    step(1); lit("lat_new",    4'b1110, 8'hC0);

    seconds = 6'd60;
    step(2); lit("dash_d1",    4'b1101, 8'hBF);
    step(4); lit("min_ones9",  4'b1011, 8'h10);
    step(4); lit("min_tens5",  4'b0111, 8'h92);
    step(4); lit("dash_d0",    4'b1110, 8'hBF);

    adj = 1'b1;
    sel = 1'b1;
    minutes = 6'd7;
    seconds = 6'd30;
    step(17); lit("blink_vis_end", 4'b1110, 8'hC0);
    step(1);  lit("blink_hid_d0",  4'b1111, 8'hFF);
    step(6);  lit("hid_min_ones",  4'b1011, 8'h78);
    step(4);  lit("hid_min_tens",  4'b0111, 8'hC0);
    step(5);  lit("hid_d0_last",   4'b1111, 8'hFF);
    step(1);  lit("vis_again",     4'b1110, 8'hC0);

    sel = 1'b0;
    step(22); lit("min_hidden",    4'b1111, 8'hFF);
    step(1);  lit("min_hidden2",   4'b1111, 8'hFF);
    sel = 1'b1;
    step(1);  lit("sel_lag",       4'b1111, 8'hFF);
    step(1);  lit("min_back",      4'b1011, 8'h78);
    step(25); lit("sec_hidden",    4'b1111, 8'hFF);
    adj = 1'b0;
    step(1);  lit("adj_lag",       4'b1111, 8'hFF);
    step(1);  lit("adj_drop",      4'b1101, 8'hB0);
    step(3);  lit("pre_rst_d2",    4'b1011, 8'h78);

    #2 rst_n = 1'b0;
    #1 lit("async_rst", 4'hF, 8'hFF);
    adj = 1'b1;
    sel = 1'b1;
    seconds = 6'd34;
    step(2);
    rst_n = 1'b1;
    step(1);  lit("post_rst_d0",   4'b1110, 8'hC0);
    step(1);  lit("post_rst_val",  4'b1110, 8'h99);
    step(3);  lit("post_rst_d1",   4'b1101, 8'hB0);
    step(12); lit("post_rst_vis",  4'b1110, 8'h99);
    step(1);  lit("post_rst_hid",  4'b1111, 8'hFF);
    step(4);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
